// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/ack arbiter in front of a single-port data memory
// (synchronous write, combinational read). Port 0 is the CPU load/store path,
// port 1 a peripheral/DMA engine. Each transaction runs IDLE -> ACCESS -> RESP,
// with round-robin resolving simultaneous requests.
// Optional build macro: DMEM_ARB_PROT_EN restricts port-1 writes to
// [P1_BASE, P1_LIMIT]. An out-of-range write is dropped and flagged on err1.
module dmem_arbiter #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] P1_BASE  = 32'h0000_0100,
  parameter logic [AW-1:0] P1_LIMIT = 32'h0000_01FC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // An empty or inverted protection window is a configuration error.
  if (P1_LIMIT < P1_BASE) begin : g_param_check
    $error("dmem_arbiter: P1_LIMIT below P1_BASE");
  end

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          grant1;
  logic          viol;

`ifdef DMEM_ARB_PROT_EN
  // Violation is judged on the latched request, so it stays stable through
  // ACCESS (write suppression) and RESP (error pulse).
  assign viol = owner_q & we_q & ((addr_q < P1_BASE) | (addr_q > P1_LIMIT));
`else
  assign viol = 1'b0;
`endif

  // Tie goes to the port that did not win last; a lone requester always wins.
  assign grant1 = (req0 & req1) ? ~last_q : req1;

  // State and datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state: grant and latch in IDLE, capture read data in ACCESS.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = grant1;
          we_d    = grant1 ? we1    : we0;
          addr_d  = grant1 ? addr1  : addr0;
          wdata_d = grant1 ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = mem_rd;
        if (owner_q) rdata1_d = mem_rd;
        else         rdata0_d = mem_rd;
        last_d  = owner_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory sees only latched values; the write strobe is confined to ACCESS.
  assign mem_a  = addr_q;
  assign mem_wd = wdata_q;
  assign mem_we = (state_q == ACCESS) & we_q & ~viol;

  assign ack0   = (state_q == RESP) & ~owner_q;
  assign ack1   = (state_q == RESP) &  owner_q;
  assign err1   = (state_q == RESP) & viol;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural data memory attached.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:255];
  logic        clr;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(
    .AW       (32),
    .DW       (32),
    .P1_BASE  (32'h0000_0100),
    .P1_LIMIT (32'h0000_01FC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .we0    (we0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .ack0   (ack0),
    .rdata0 (rdata0),
    .req1   (req1),
    .we1    (we1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .ack1   (ack1),
    .rdata1 (rdata1),
    .err1   (err1),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read, word indexed.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a[9:2]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the given port's ack is seen; lat counts edges.
  task automatic wait_ack(input bit port, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(port ? ack1 : ack0) && lat < 10);
  endtask

  // One complete transaction from an idle arbiter; checks latency and
  // that the other port stays quiet, then returns with the FSM in IDLE.
  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic err);
    int lat;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    wait_ack(port, lat);
    check_eq(port ? "lat1" : "lat0", lat, 2);
    check_eq(port ? "ack0_quiet" : "ack1_quiet", port ? ack0 : ack1, 0);
    rd  = port ? rdata1 : rdata0;
    err = err1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
    step();
    check_eq("ack_one_cycle", {ack0, ack1}, 0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;
  logic [3:0]  grants;

  initial begin
    reset = 1'b1; clr = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    step();
    clr = 1'b0;
    check_eq("rst_ack", {ack0, ack1, err1, mem_we}, 0);
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_rdata1", rdata1, 0);
    check_eq("rst_mem_a", mem_a, 0);
    reset = 1'b0;

    // Port 0 write then read back.
    run_txn(0, 1, 32'h04, 32'hDEADBEEF, rd, er);
    run_txn(0, 0, 32'h04, 32'h0, rd, er);
    check_eq("p0_readback", rd, 32'hDEADBEEF);

    // Preload for the contention test.
    run_txn(0, 1, 32'h00, 32'h11111111, rd, er);
    run_txn(0, 1, 32'h08, 32'h22222222, rd, er);

    // Continuous contention from reset: grants must alternate 0,1,0,1.
    reset = 1'b1;
    req0 = 1; we0 = 0; addr0 = 32'h00;
    req1 = 1; we1 = 0; addr1 = 32'h08;
    step();
    reset = 1'b0;
    n = 0; grants = '0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (ack0 | ack1) begin
        check_eq("single_ack", {ack0, ack1} == 2'b11, 0);
        grants[n] = ack1;
        if (ack1) check_eq("cont_rdata1", rdata1, 32'h22222222);
        else      check_eq("cont_rdata0", rdata0, 32'h11111111);
        n++;
      end
    end
    req0 = 0; req1 = 0;
    check_eq("cont_count", n, 4);
    check_eq("cont_order", grants, 4'b1010);
    step();

    // Inputs changed after latch must not affect the in-flight access.
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'h12345678;
    step();
    addr0 = 32'h14; wdata0 = 32'hFFFFFFFF;
    check_eq("latch_we", mem_we, 1);
    check_eq("latch_a", mem_a, 32'h10);
    check_eq("latch_wd", mem_wd, 32'h12345678);
    step();
    check_eq("latch_ack0", ack0, 1);
    check_eq("rdata1_hold", rdata1, 32'h22222222);
    check_eq("resp_we_low", mem_we, 0);
    req0 = 0;
    step();
    check_eq("mem_10", mem[4], 32'h12345678);
    check_eq("mem_14", mem[5], 0);
    check_eq("idle_a_hold", mem_a, 32'h10);
    req0 = 1; we0 = 0; addr0 = 32'h10;
    step();
    addr0 = 32'h04;
    step();
    check_eq("latch_rd_ack", ack0, 1);
    check_eq("latch_rdata0", rdata0, 32'h12345678);
    req0 = 0;
    step();

    // Port 1 write in its window, port 0 reads it back.
    run_txn(1, 1, 32'h104, 32'hCAFE0001, rd, er);
    check_eq("p1_win_err", er, 0);
    run_txn(0, 0, 32'h104, 32'h0, rd, er);
    check_eq("p1_write_seen", rd, 32'hCAFE0001);

    // Port 1 write below the window.
    run_txn(1, 1, 32'h20, 32'hBAD00000, rd, er);
`ifdef DMEM_ARB_PROT_EN
    check_eq("prot_err", er, 1);
    check_eq("prot_mem20", mem[8], 0);
`else
    check_eq("noprot_err", er, 0);
    check_eq("noprot_mem20", mem[8], 32'hBAD00000);
`endif
    run_txn(1, 1, 32'h100, 32'hBAD00000, rd, er);
    check_eq("base_err", er, 0);
    check_eq("base_mem100", mem[64], 32'hBAD00000);

    // Reset in the middle of a port-0 write.
    req0 = 1; we0 = 1; addr0 = 32'h0C; wdata0 = 32'hA5A5A5A5;
    step();
    check_eq("pre_rst_we", mem_we, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_async_we", mem_we, 0);
    check_eq("rst_async_ack", {ack0, ack1}, 0);
    check_eq("rst_async_rdata0", rdata0, 0);
    req0 = 0;
    step();
    check_eq("rst_no_commit", mem[3], 0);
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 32'h0C;
    req1 = 1; we1 = 0; addr1 = 32'h00;
    lat = 0;
    do begin step(); lat++; end while (!(ack0 | ack1) && lat < 10);
    check_eq("rst_tie_port0", {ack0, ack1}, 2'b10);
    check_eq("rst_read_0c", rdata0, 0);
    req0 = 0;
    wait_ack(1, lat);
    check_eq("rst_then_p1", ack1, 1);
    check_eq("rst_p1_rdata", rdata1, 32'h11111111);
    req1 = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
